// File: rtl/dmem_arbiter.sv
// Purpose : shares one data-memory port between the CPU (default owner, no handshake) and a loader (req/ack).
// Latency : combinational; the loader is acked in the cycle its access reaches memory.
// Backpress: the CPU is stalled while the loader owns memory; loader waits are bounded by MAX_WAIT.
//
// Ports:
//   clock, reset                    rising-edge clock, synchronous active-high reset
//   cpu_addr/wdata/write/read       CPU access request; cpu_rdata and cpu_stall go back to it
//   ld_req/we/addr/wdata/lock       loader access request (held until ld_ack); ld_ack and ld_rdata go back to it
//   mem_addr/wdata/write/read       shared memory port; mem_rdata is its combinational read data
//   owner                           0 = CPU owns memory, 1 = loader owns memory
module dmem_arbiter #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_write,
  input  logic              cpu_read,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_lock,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);

  typedef enum logic {
    CPU_OWN = 1'b0,
    LD_OWN  = 1'b1
  } state_t;

  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(MAX_WAIT - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_cnt_nxt;
  logic [BW-1:0] burst_cnt, burst_cnt_nxt;
  logic          cpu_active;

  assign cpu_active = cpu_read | cpu_write;
  assign cpu_rdata  = mem_rdata;
  assign ld_rdata   = mem_rdata;
  assign owner      = (state == LD_OWN);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= CPU_OWN;
      wait_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    burst_cnt_nxt = burst_cnt;
    mem_addr      = cpu_addr;
    mem_wdata     = cpu_wdata;
    mem_write     = cpu_write;
    mem_read      = cpu_read;
    cpu_stall     = 1'b0;
    ld_ack        = 1'b0;

    case (state)
      CPU_OWN: begin
        // The CPU access in this cycle always goes through; the loader
        // takes over next cycle when the CPU is idle or has waited long enough.
        if (ld_req && (!cpu_active || wait_cnt == WAIT_LAST)) begin
          state_nxt     = LD_OWN;
          wait_cnt_nxt  = '0;
          burst_cnt_nxt = '0;
        end else if (ld_req) begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end else begin
          wait_cnt_nxt = '0;
        end
      end
      LD_OWN: begin
        cpu_stall = 1'b1;
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
        mem_write = ld_req & ld_we;
        mem_read  = ld_req & ~ld_we;
        ld_ack    = ld_req;
        // Staying requires a locked request and room for one more access;
        // burst_cnt < MAX_BURST-1 is the same test as burst_cnt+1 < MAX_BURST.
        if (ld_req && ld_lock && burst_cnt < BURST_LAST) begin
          burst_cnt_nxt = burst_cnt + 1'b1;
        end else begin
          state_nxt     = CPU_OWN;
          burst_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt = CPU_OWN;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose : self-checking bench for dmem_arbiter with a small behavioural data memory.
// Latency : one row / one step per clock cycle; outputs compared mid-cycle.
// Backpress: none; all sequences run a fixed number of cycles.
module tb_dmem_arbiter;

  logic        clock;
  logic        reset;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_write, cpu_read, cpu_stall;
  logic        ld_req, ld_we, ld_lock, ld_ack;
  logic [15:0] ld_addr, ld_wdata, ld_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read, owner;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.DATA_W(16), .ADDR_W(16), .MAX_WAIT(4), .MAX_BURST(8)) dut (
    .clock(clock), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_write(cpu_write), .cpu_read(cpu_read),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_lock(ld_lock),
    .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  // Behavioural memory: combinational read, write on rising edge,
  // preloaded with 0xA5xx so unwritten locations are recognisable.
  logic [15:0] mem [256];
  logic        mem_init;
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hA500 | 16'(i);
    end else if (mem_write) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // rd_chk: 0 = none, 1 = cpu_rdata, 2 = ld_rdata
  typedef struct {
    logic        rst;
    logic        c_rd, c_wr;
    logic [15:0] c_addr, c_wd;
    logic        l_req, l_we, l_lock;
    logic [15:0] l_addr, l_wd;
    logic        chk_en;
    logic        e_own, e_stall, e_ack, e_mw, e_mr;
    logic [15:0] e_maddr;
    int          rd_chk;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic c_rd, input logic c_wr,
                     input logic [15:0] c_addr, input logic [15:0] c_wd,
                     input logic l_req, input logic l_we, input logic l_lock,
                     input logic [15:0] l_addr, input logic [15:0] l_wd,
                     input logic chk_en, input logic e_own, input logic e_stall,
                     input logic e_ack, input logic e_mw, input logic e_mr,
                     input logic [15:0] e_maddr, input int rd_chk, input logic [15:0] e_rdata);
    vec_t v;
    v.rst = rst; v.c_rd = c_rd; v.c_wr = c_wr; v.c_addr = c_addr; v.c_wd = c_wd;
    v.l_req = l_req; v.l_we = l_we; v.l_lock = l_lock; v.l_addr = l_addr; v.l_wd = l_wd;
    v.chk_en = chk_en; v.e_own = e_own; v.e_stall = e_stall; v.e_ack = e_ack;
    v.e_mw = e_mw; v.e_mr = e_mr; v.e_maddr = e_maddr; v.rd_chk = rd_chk; v.e_rdata = e_rdata;
    vecs.push_back(v);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
    mem_init = 1'b0;
  endtask

  // Compare owner/stall/ack mid-cycle, then advance one clock.
  task automatic step_chk(input string name, input logic e_own, input logic e_stall, input logic e_ack);
    #4;
    chk({name, ".owner"}, {15'd0, owner}, {15'd0, e_own});
    chk({name, ".stall"}, {15'd0, cpu_stall}, {15'd0, e_stall});
    chk({name, ".ack"}, {15'd0, ld_ack}, {15'd0, e_ack});
    next_cycle();
  endtask

  task automatic cpu_read_chk(input string name, input logic [15:0] a, input logic [15:0] exp);
    reset = 1'b0; ld_req = 1'b0; cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = a;
    #4;
    chk(name, cpu_rdata, exp);
    next_cycle();
  endtask

  initial begin
    reset = 1'b1; mem_init = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    ld_req = 1'b0; ld_we = 1'b0; ld_lock = 1'b0; ld_addr = '0; ld_wdata = '0;

    //   rst rd wr c_addr    c_wd      req we lk l_addr    l_wd      chk own stl ack mw mr maddr    rd data
    add(1, 1, 0, 16'h0010, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h0010, 0, 16'h0000);
    add(1, 1, 0, 16'h0010, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 1, 16'h0010, 0, 16'h0000);
    add(0, 1, 0, 16'h0010, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 1, 16'h0010, 1, 16'hA510);
    // idle CPU: loader write granted next cycle, then ownership returns
    add(0, 0, 0, 16'h0010, 16'h0000, 1, 1, 0, 16'h0020, 16'h1234, 1, 0, 0, 0, 0, 0, 16'h0010, 0, 16'h0000);
    add(0, 0, 0, 16'h0010, 16'h0000, 1, 1, 0, 16'h0020, 16'h1234, 1, 1, 1, 1, 1, 0, 16'h0020, 0, 16'h0000);
    add(0, 1, 0, 16'h0020, 16'h0000, 0, 0, 0, 16'h0020, 16'h0000, 1, 0, 0, 0, 0, 1, 16'h0020, 1, 16'h1234);
    // plain CPU write then read back
    add(0, 0, 1, 16'h0030, 16'hBEEF, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 1, 0, 16'h0030, 0, 16'h0000);
    add(0, 1, 0, 16'h0030, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 1, 16'h0030, 1, 16'hBEEF);
    // grant then loader drops its request: dead stall cycle, no write
    add(0, 0, 0, 16'h0040, 16'h0000, 1, 1, 0, 16'h0040, 16'hDEAD, 1, 0, 0, 0, 0, 0, 16'h0040, 0, 16'h0000);
    add(0, 1, 0, 16'h0040, 16'h0000, 0, 1, 0, 16'h0040, 16'hDEAD, 1, 1, 1, 0, 0, 0, 16'h0040, 0, 16'h0000);
    add(0, 1, 0, 16'h0040, 16'h0000, 0, 1, 0, 16'h0040, 16'hDEAD, 1, 0, 0, 0, 0, 1, 16'h0040, 1, 16'hA540);
    // loader read
    add(0, 0, 0, 16'h0010, 16'h0000, 1, 0, 0, 16'h0020, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0010, 0, 16'h0000);
    add(0, 0, 0, 16'h0010, 16'h0000, 1, 0, 0, 16'h0020, 16'h0000, 1, 1, 1, 1, 0, 1, 16'h0020, 2, 16'h1234);
    add(0, 0, 0, 16'h0010, 16'h0000, 0, 0, 0, 16'h0020, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0010, 0, 16'h0000);

    for (int r = 0; r < vecs.size(); r++) begin
      reset = vecs[r].rst; cpu_read = vecs[r].c_rd; cpu_write = vecs[r].c_wr;
      cpu_addr = vecs[r].c_addr; cpu_wdata = vecs[r].c_wd;
      ld_req = vecs[r].l_req; ld_we = vecs[r].l_we; ld_lock = vecs[r].l_lock;
      ld_addr = vecs[r].l_addr; ld_wdata = vecs[r].l_wd;
      #4;
      if (vecs[r].chk_en) begin
        chk($sformatf("vec%0d.owner", r), {15'd0, owner}, {15'd0, vecs[r].e_own});
        chk($sformatf("vec%0d.stall", r), {15'd0, cpu_stall}, {15'd0, vecs[r].e_stall});
        chk($sformatf("vec%0d.ack", r), {15'd0, ld_ack}, {15'd0, vecs[r].e_ack});
        chk($sformatf("vec%0d.mem_write", r), {15'd0, mem_write}, {15'd0, vecs[r].e_mw});
        chk($sformatf("vec%0d.mem_read", r), {15'd0, mem_read}, {15'd0, vecs[r].e_mr});
        chk($sformatf("vec%0d.mem_addr", r), mem_addr, vecs[r].e_maddr);
        if (vecs[r].rd_chk == 1) chk($sformatf("vec%0d.cpu_rdata", r), cpu_rdata, vecs[r].e_rdata);
        if (vecs[r].rd_chk == 2) chk($sformatf("vec%0d.ld_rdata", r), ld_rdata, vecs[r].e_rdata);
      end
      next_cycle();
    end

    // Bounded wait: CPU reads every cycle, loader request held; grant at t+4.
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 16'h0050;
    ld_req = 1'b1; ld_we = 1'b0; ld_lock = 1'b0; ld_addr = 16'h0020;
    for (int k = 0; k < 5; k++) begin
      step_chk($sformatf("wait%0d", k), k == 4, k == 4, k == 4);
    end
    ld_req = 1'b0;
    step_chk("wait_after", 1'b0, 1'b0, 1'b0);

    // Locked burst: 8 acks, one CPU cycle, re-grant, burst resumes.
    cpu_read = 1'b0; ld_req = 1'b1; ld_we = 1'b1; ld_lock = 1'b1;
    for (int c = 0; c < 13; c++) begin
      ld_addr = 16'h0060 + 16'(c); ld_wdata = 16'h7000 + 16'(c);
      if (c == 0 || c == 9) step_chk($sformatf("burst%0d", c), 1'b0, 1'b0, 1'b0);
      else                  step_chk($sformatf("burst%0d", c), 1'b1, 1'b1, 1'b1);
    end
    ld_req = 1'b0;
    step_chk("burst_drop", 1'b1, 1'b1, 1'b0);
    cpu_read_chk("burst_mem60", 16'h0060, 16'hA560);
    cpu_read_chk("burst_mem68", 16'h0068, 16'h7008);
    cpu_read_chk("burst_mem69", 16'h0069, 16'hA569);
    cpu_read_chk("burst_mem6A", 16'h006A, 16'h700A);

    // Reset during the 3rd access of a burst: access still acked, then CPU_OWN.
    cpu_read = 1'b0; ld_req = 1'b1; ld_we = 1'b1; ld_lock = 1'b1;
    ld_addr = 16'h0080; ld_wdata = 16'h5555;
    step_chk("rst_grant", 1'b0, 1'b0, 1'b0);
    step_chk("rst_acc1", 1'b1, 1'b1, 1'b1);
    step_chk("rst_acc2", 1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    step_chk("rst_acc3", 1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    step_chk("rst_after", 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      step_chk($sformatf("rst_burst%0d", c), 1'b1, 1'b1, 1'b1);
    end
    step_chk("rst_burst_end", 1'b0, 1'b0, 1'b0);
    ld_req = 1'b0;
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (DMemory_IO, including its 7-seg/switch I/O addresses) between two requesters: the PMIPSL0 processor and a loader/debug master (program/data loader, bench probe).
- The processor is the default owner and uses a no-handshake access model.
- The loader uses a req/ack handshake.
- While the loader owns memory, the arbiter stalls the processor.
- A bounded-wait counter and a burst limit guarantee forward progress for both requesters.

Parameters:
- DATA_W, 16, data width of memory and both requesters
- ADDR_W, 16, address width
- MAX_WAIT, 4, maximum cycles a pending loader request waits in CPU_OWN before forced grant (>=1)
- MAX_BURST, 8, maximum consecutive loader accesses in one LD_OWN tenure (>=1)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- cpu_addr  in  ADDR_W  processor data address
- cpu_wdata  in  DATA_W  processor write data
- cpu_write  in  1  processor write enable
- cpu_read  in  1  processor read enable
- cpu_rdata  out  DATA_W  read data to processor (= mem_rdata)
- cpu_stall  out  1  processor must hold state this cycle; its access is not performed
- ld_req  in  1  loader access request; held until ld_ack
- ld_we  in  1  loader write (1) / read (0)
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  DATA_W  loader write data
- ld_lock  in  1  loader requests back-to-back ownership (burst)
- ld_ack  out  1  loader access performed this cycle
- ld_rdata  out  DATA_W  read data to loader (= mem_rdata), valid when ld_ack=1 and ld_we=0
- mem_addr  out  ADDR_W  to data memory
- mem_wdata  out  DATA_W  to data memory
- mem_write  out  1  to data memory
- mem_read  out  1  to data memory
- mem_rdata  in  DATA_W  from data memory (combinational read; write on rising clock)
- owner  out  1  0=CPU_OWN, 1=LD_OWN (state register)

Behaviour:
- Two-state FSM registered on clock.
- Counters: wait_cnt (0..MAX_WAIT-1) and burst_cnt (0..MAX_BURST), minimum width.
- Reset (sync): state=CPU_OWN, wait_cnt=0, burst_cnt=0. Outputs then: owner=0, cpu_stall=0, ld_ack=0, memory port mirrors the CPU inputs.
- CPU_OWN:
  - mem_* = cpu_*; cpu_stall=0; ld_ack=0.
  - cpu_active = cpu_read | cpu_write.
  - Go to LD_OWN when ld_req & (!cpu_active | wait_cnt==MAX_WAIT-1). On that transition clear wait_cnt and burst_cnt.
  - Otherwise: wait_cnt++ if ld_req, else wait_cnt=0.
  - The CPU access in this cycle is always performed.
- LD_OWN:
  - cpu_stall=1.
  - mem_addr=ld_addr, mem_wdata=ld_wdata, mem_write=ld_req&ld_we, mem_read=ld_req&!ld_we.
  - ld_ack=ld_req (one access per cycle, zero added latency).
  - On ld_ack: burst_cnt++.
  - Stay in LD_OWN iff ld_req & ld_lock & (burst_cnt+1 < MAX_BURST). Otherwise go to CPU_OWN with burst_cnt=0.
  - ld_req low in LD_OWN: no access, no ack, return to CPU_OWN (one dead stall cycle).
- CPU writes are never issued while cpu_stall=1. The processor must hold its PC and all inputs stable.
- Guarantees:
  - Loader waits at most MAX_WAIT cycles in CPU_OWN.
  - CPU gets at least one CPU_OWN cycle after every MAX_BURST loader accesses.
- Simultaneous events:
  - ld_req rises in a cycle where the CPU is idle: grant takes effect the next cycle.
  - A CPU request in that next cycle is stalled.
- Reset in LD_OWN: the access in the reset cycle is still performed if ld_req=1 (combinational path). The state returns to CPU_OWN the next cycle.
- ld_lock is sampled only in LD_OWN cycles with ld_ack=1.

Test Plan:
- Reset held 2 cycles, CPU read addr 0x0010 -> owner=0, cpu_stall=0, mem_addr=0x0010, mem_read=1, ld_ack=0.
- CPU idle, ld_req=1, ld_we=1, ld_addr=0x0020, ld_wdata=0x1234 -> next cycle owner=1, ld_ack=1, mem_write=1. Following cycle owner=0. A later CPU read of 0x0020 returns 0x1234.
- CPU reading every cycle, ld_req held from cycle t, MAX_WAIT=4 -> LD_OWN entered at t+4, ld_ack at t+4, cpu_stall=1 only in that cycle.
- ld_lock=1, ld_req continuous, MAX_BURST=8 -> exactly 8 consecutive acks, then 1 CPU_OWN cycle with cpu_stall=0, then re-grant (CPU idle) and the burst resumes.
- LD_OWN entered, ld_req dropped same cycle -> ld_ack=0, no mem_write, owner=0 the next cycle.
- reset asserted mid-burst (3rd access) -> next cycle owner=0, cpu_stall=0, burst_cnt=0. A subsequent locked burst again allows 8 accesses.
